// File: rtl/instr_pkg.sv
// Opcodes, instruction word layout and the fixed coprocessor program.
// Word layout: {opcode[21:18], dst[17:12], src_a[11:6], src_b[5:0]}.
package instr_pkg;

   localparam int INSTR_W   = 22;
   localparam int ROM_DEPTH = 32;
   localparam int REG_W     = 6;

   typedef logic [INSTR_W-1:0] word_t;

   typedef enum logic [3:0] {
      LOAD   = 4'b0010,
      ADD    = 4'b0011,
      SUB    = 4'b0100,
      MUL    = 4'b0101,
      TRANSP = 4'b0110,
      OPP    = 4'b0111,
      DET    = 4'b1011
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      ADVANCE
   } seq_state_t;

   function automatic word_t mk_instr(input opcode_t op, input int dst,
                                      input int src_a, input int src_b);
      return {op, REG_W'(dst), REG_W'(src_a), REG_W'(src_b)};
   endfunction

   // Matrix program; the tail past the program length is never addressed.
   localparam word_t PROG_ROM [ROM_DEPTH] = '{
      mk_instr(LOAD,    1,  0,  0),
      mk_instr(LOAD,    2,  1,  0),
      mk_instr(ADD,     3,  1,  2),
      mk_instr(SUB,     4,  1,  2),
      mk_instr(MUL,     5,  1,  2),
      mk_instr(TRANSP,  6,  5,  0),
      mk_instr(OPP,     7,  6,  0),
      mk_instr(DET,     8,  5,  0),
      mk_instr(LOAD,    9,  2,  0),
      mk_instr(ADD,    10,  3,  9),
      mk_instr(MUL,    11, 10,  4),
      mk_instr(TRANSP, 12, 11,  0),
      mk_instr(SUB,    13, 12,  7),
      mk_instr(DET,    14, 13,  0),
      mk_instr(OPP,    15, 14,  0),
      mk_instr(LOAD,   16,  3,  0),
      mk_instr(ADD,    17, 16, 15),
      mk_instr(MUL,    18, 17, 17),
      mk_instr(DET,    19, 18,  0),
      mk_instr(SUB,    20, 19,  8),
      mk_instr(ADD,    21, 20,  1),
      word_t'(0), word_t'(0), word_t'(0), word_t'(0),
      word_t'(0), word_t'(0), word_t'(0), word_t'(0),
      word_t'(0), word_t'(0), word_t'(0)
   };

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-count debounce and
// rising-edge detector producing a single step pulse per press.
module btn_debounce #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic step
);

   localparam int CNT_W = $clog2(DB_CYCLES + 1);

   logic [1:0]       sync_q;
   logic             pressed;
   logic             level_q;
   logic             level_dly_q;
   logic [CNT_W-1:0] cnt_q;

   // Reset value 1 means the button reads as released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], btn_n};
      end
   end

   assign pressed = ~sync_q[1];

   // The level flips on the DB_CYCLES-th consecutive sample that disagrees.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else if (pressed == level_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
         cnt_q   <= '0;
         level_q <= pressed;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_dly_q <= 1'b0;
      end else begin
         level_dly_q <= level_q;
      end
   end

   assign step = level_q & ~level_dly_q;

endmodule

// File: rtl/instr_sequencer.sv
// Steps a constant program out to a coprocessor over a valid/ready handshake.
// Define AUTORUN_EN to stream the program continuously; a step then restarts at word 0.
module instr_sequencer #(
   parameter int INSTR_W   = instr_pkg::INSTR_W,
   parameter int PROG_LEN  = 21,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               step_btn,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [4:0]         pc,
   output logic               wrapped
);

   import instr_pkg::*;

   localparam logic [4:0] LAST_PC = 5'(PROG_LEN - 1);

   seq_state_t         state_q, state_d;
   logic [4:0]         pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q;
   logic               wrapped_q, wrapped_d;
   logic               step;

   btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
   ) u_btn_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .btn_n(step_btn),
      .step (step)
   );

`ifdef AUTORUN_EN
   logic restart_q, restart_d;

   // A step can land in any state while streaming, so it is held until ADVANCE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         restart_q <= 1'b0;
      end else begin
         restart_q <= restart_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         instr_q   <= '0;
         wrapped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= INSTR_W'(PROG_ROM[pc_d]);
         wrapped_q <= wrapped_d;
      end
   end

   // The instr register tracks the next pc, so the word is settled before ISSUE.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      wrapped_d = 1'b0;
`ifdef AUTORUN_EN
      restart_d = restart_q | step;
`endif
      case (state_q)
         IDLE: begin
`ifdef AUTORUN_EN
            state_d = ISSUE;
`else
            if (step) begin
               state_d = ISSUE;
            end
`endif
         end
         ISSUE: begin
            if (instr_ready) begin
               state_d = ADVANCE;
            end
         end
         ADVANCE: begin
            if (pc_q == LAST_PC) begin
               pc_d      = '0;
               wrapped_d = 1'b1;
            end else begin
               pc_d = pc_q + 5'd1;
            end
`ifdef AUTORUN_EN
            if (restart_q || step) begin
               pc_d = '0;
            end
            restart_d = 1'b0;
            state_d   = ISSUE;
`else
            state_d = IDLE;
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign instr       = instr_q;
   assign instr_valid = (state_q == ISSUE);
   assign pc          = pc_q;
   assign wrapped     = wrapped_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: debounce, handshake stalls, wrap and reset.
// The AUTORUN_EN build runs the streaming checks instead of the step table.
`timescale 1ns/1ps
module tb_instr_sequencer;

   localparam int INSTR_W   = 22;
   localparam int PROG_LEN  = 21;
   localparam int DB_CYCLES = 4;
   localparam int NUM_VECS  = 26;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               step_btn = 1'b1;
   logic               instr_ready = 1'b0;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic [4:0]         pc;
   logic               wrapped;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      int           stall;
      bit           extra_press;
      logic [4:0]   exp_pc;
      logic [21:0]  exp_instr;
      logic [4:0]   exp_pc_after;
      bit           exp_wrap;
   } vec_t;

   vec_t vecs [NUM_VECS];

   always #5 clk = ~clk;

   instr_sequencer #(
      .INSTR_W  (INSTR_W),
      .PROG_LEN (PROG_LEN),
      .DB_CYCLES(DB_CYCLES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .step_btn   (step_btn),
      .instr      (instr),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .pc         (pc),
      .wrapped    (wrapped)
   );

   // Reference program: {opcode, dst, src_a, src_b}.
   function automatic logic [21:0] ref_word(input int idx);
      logic [3:0] op;
      int d, a, b;
      case (idx)
         0:  begin op = 4'b0010; d = 1;  a = 0;  b = 0;  end
         1:  begin op = 4'b0010; d = 2;  a = 1;  b = 0;  end
         2:  begin op = 4'b0011; d = 3;  a = 1;  b = 2;  end
         3:  begin op = 4'b0100; d = 4;  a = 1;  b = 2;  end
         4:  begin op = 4'b0101; d = 5;  a = 1;  b = 2;  end
         5:  begin op = 4'b0110; d = 6;  a = 5;  b = 0;  end
         6:  begin op = 4'b0111; d = 7;  a = 6;  b = 0;  end
         7:  begin op = 4'b1011; d = 8;  a = 5;  b = 0;  end
         8:  begin op = 4'b0010; d = 9;  a = 2;  b = 0;  end
         9:  begin op = 4'b0011; d = 10; a = 3;  b = 9;  end
         10: begin op = 4'b0101; d = 11; a = 10; b = 4;  end
         11: begin op = 4'b0110; d = 12; a = 11; b = 0;  end
         12: begin op = 4'b0100; d = 13; a = 12; b = 7;  end
         13: begin op = 4'b1011; d = 14; a = 13; b = 0;  end
         14: begin op = 4'b0111; d = 15; a = 14; b = 0;  end
         15: begin op = 4'b0010; d = 16; a = 3;  b = 0;  end
         16: begin op = 4'b0011; d = 17; a = 16; b = 15; end
         17: begin op = 4'b0101; d = 18; a = 17; b = 17; end
         18: begin op = 4'b1011; d = 19; a = 18; b = 0;  end
         19: begin op = 4'b0100; d = 20; a = 19; b = 8;  end
         20: begin op = 4'b0011; d = 21; a = 20; b = 1;  end
         default: begin op = 4'b0000; d = 0; a = 0; b = 0; end
      endcase
      return {op, 6'(d), 6'(a), 6'(b)};
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic wait_valid(input int budget, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(negedge clk);
         seen = instr_valid;
      end
   endtask

   // One press: issue, optional stall (with an ignored second press), transfer, release.
   task automatic apply_stimulus(input vec_t v);
      bit seen, unstable, repeat_seen;
      logic [21:0] held_instr;
      instr_ready = (v.stall == 0);
      step_btn    = 1'b0;
      wait_valid(30, seen);
      check_output("issue_seen", 32'(seen), 32'd1);
      if (!seen) begin
         step_btn    = 1'b1;
         instr_ready = 1'b1;
         repeat (20) @(negedge clk);
         return;
      end
      check_output("issue_instr", 32'(instr), 32'(v.exp_instr));
      check_output("issue_pc", 32'(pc), 32'(v.exp_pc));
      if (v.stall > 0) begin
         held_instr = instr;
         unstable   = 1'b0;
         for (int c = 0; c < v.stall; c++) begin
            if (v.extra_press) begin
               if (c == 0)       step_btn = 1'b1;
               else if (c == 8)  step_btn = 1'b0;
               else if (c == 16) step_btn = 1'b1;
            end
            @(negedge clk);
            if (!instr_valid || instr !== held_instr) unstable = 1'b1;
         end
         check_output("stall_stable", 32'(unstable), 32'd0);
         instr_ready = 1'b1;
      end
      @(negedge clk);
      check_output("valid_drop", 32'(instr_valid), 32'd0);
      @(negedge clk);
      check_output("pc_after", 32'(pc), 32'(v.exp_pc_after));
      check_output("wrap_pulse", 32'(wrapped), 32'(v.exp_wrap));
      @(negedge clk);
      check_output("wrap_clear", 32'(wrapped), 32'd0);
      repeat_seen = 1'b0;
      for (int c = 0; c < 24; c++) begin
         if (c == 12) step_btn = 1'b1;
         @(negedge clk);
         if (instr_valid) repeat_seen = 1'b1;
      end
      check_output("no_repeat", 32'(repeat_seen), 32'd0);
   endtask

`ifdef AUTORUN_EN
   task automatic run_autorun();
      int last_c, n;
      bit bad_pc, bad_gap, restart_seen;
      logic [4:0] prev_pc;
      instr_ready = 1'b1;
      last_c  = -1;
      n       = 0;
      bad_pc  = 1'b0;
      bad_gap = 1'b0;
      for (int c = 0; c < 200 && n < 22; c++) begin
         @(negedge clk);
         if (instr_valid) begin
            if (pc !== 5'(n % PROG_LEN)) bad_pc = 1'b1;
            if (instr !== ref_word(n % PROG_LEN)) bad_pc = 1'b1;
            if (last_c >= 0 && c - last_c != 2) bad_gap = 1'b1;
            last_c = c;
            n++;
         end
      end
      check_output("auto_transfers", 32'(n), 32'd22);
      check_output("auto_sequence", 32'(bad_pc), 32'd0);
      check_output("auto_spacing", 32'(bad_gap), 32'd0);
      repeat (6) @(negedge clk);
      step_btn     = 1'b0;
      prev_pc      = pc;
      restart_seen = 1'b0;
      for (int c = 0; c < 40 && !restart_seen; c++) begin
         @(negedge clk);
         if (instr_valid) begin
            if (pc == 5'd0 && prev_pc != LAST_IDX()) restart_seen = 1'b1;
            prev_pc = pc;
         end
      end
      check_output("auto_restart", 32'(restart_seen), 32'd1);
      step_btn = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   function automatic logic [4:0] LAST_IDX();
      return 5'(PROG_LEN - 1);
   endfunction
`endif

   initial begin
      bit seen, glitch_seen, early;

      for (int i = 0; i < NUM_VECS; i++) begin
         int idx;
         idx = i % PROG_LEN;
         vecs[i].stall        = (i == 2) ? 30 : (i == 6) ? 10 : (i == 20) ? 3 : 0;
         vecs[i].extra_press  = (i == 2);
         vecs[i].exp_pc       = 5'(idx);
         vecs[i].exp_instr    = ref_word(idx);
         vecs[i].exp_pc_after = (idx == PROG_LEN - 1) ? 5'd0 : 5'(idx + 1);
         vecs[i].exp_wrap     = (idx == PROG_LEN - 1);
      end

      rst_n       = 1'b0;
      step_btn    = 1'b1;
      instr_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_output("reset_valid", 32'(instr_valid), 32'd0);
      check_output("reset_instr", 32'(instr), 32'd0);
      check_output("reset_pc", 32'(pc), 32'd0);
      check_output("reset_wrapped", 32'(wrapped), 32'd0);
      rst_n = 1'b1;

`ifdef AUTORUN_EN
      run_autorun();
`else
      repeat (5) @(negedge clk);
      check_output("idle_no_valid", 32'(instr_valid), 32'd0);

      // Presses shorter than the debounce window must never issue.
      instr_ready = 1'b1;
      glitch_seen = 1'b0;
      for (int g = 0; g < 5; g++) begin
         step_btn = 1'b0;
         repeat (3) begin @(negedge clk); glitch_seen |= instr_valid; end
         step_btn = 1'b1;
         repeat (3) begin @(negedge clk); glitch_seen |= instr_valid; end
      end
      repeat (10) begin @(negedge clk); glitch_seen |= instr_valid; end
      check_output("glitch_no_issue", 32'(glitch_seen), 32'd0);
      check_output("glitch_pc", 32'(pc), 32'd0);

      for (int i = 0; i < NUM_VECS; i++) begin
         apply_stimulus(vecs[i]);
      end

      // Reset while offering word 5, with the button held through reset release.
      instr_ready = 1'b0;
      step_btn    = 1'b0;
      wait_valid(30, seen);
      check_output("rst_issue_seen", 32'(seen), 32'd1);
      check_output("rst_issue_pc", 32'(pc), 32'd5);
      check_output("rst_issue_instr", 32'(instr), 32'(ref_word(5)));
      #2 rst_n = 1'b0;
      #1;
      check_output("rst_async_valid", 32'(instr_valid), 32'd0);
      check_output("rst_async_instr", 32'(instr), 32'd0);
      check_output("rst_async_pc", 32'(pc), 32'd0);
      check_output("rst_async_wrapped", 32'(wrapped), 32'd0);
      @(negedge clk);
      rst_n       = 1'b1;
      instr_ready = 1'b1;
      early       = 1'b0;
      for (int c = 0; c < DB_CYCLES; c++) begin
         @(negedge clk);
         early |= instr_valid;
      end
      check_output("held_no_early_step", 32'(early), 32'd0);
      wait_valid(30, seen);
      check_output("held_issue_seen", 32'(seen), 32'd1);
      check_output("held_issue_instr", 32'(instr), 32'(ref_word(0)));
      check_output("held_issue_pc", 32'(pc), 32'd0);
      repeat (2) @(negedge clk);
      check_output("held_pc_after", 32'(pc), 32'd1);
      step_btn = 1'b1;
      repeat (10) @(negedge clk);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter INSTR_W, default 22, coprocessor instruction width.
REQ-002 SHALL have parameter PROG_LEN, default 21, number of program words (2..32).
REQ-003 SHALL have parameter DB_CYCLES, default 1_000_000, debounce stable-count in clk cycles.
REQ-004 SHALL have port clk  input  1  system clock; all flops on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port step_btn  input  1  raw step push-button, active-low, asynchronous.
REQ-007 SHALL have port instr  output  INSTR_W  instruction presented to coprocessor.
REQ-008 SHALL have port instr_valid  output  1  instr is valid and being offered.
REQ-009 SHALL have port instr_ready  input  1  coprocessor accepts instr this cycle.
REQ-010 SHALL have port pc  output  5  index of the word currently held in instr.
REQ-011 SHALL have port wrapped  output  1  one-cycle pulse when pc returns to 0.

Function
REQ-012 SHALL pass step_btn through a 2-flop synchronizer, then invert to active-high.
REQ-013 SHALL debounce with a counter: filtered level changes only after DB_CYCLES consecutive equal synchronized samples; counter clears on any mismatch.
REQ-014 SHALL generate one step pulse on each rising edge of the filtered level; holding the button yields exactly one pulse.
REQ-015 SHALL implement FSM states IDLE, ISSUE, ADVANCE.
REQ-016 IDLE: instr_valid=0; step pulse -> ISSUE.
REQ-017 ISSUE: instr_valid=1, instr=ROM[pc] held stable; instr_valid&instr_ready -> ADVANCE; instr_ready low -> stay (no timeout).
REQ-018 ADVANCE (one cycle): pc <= pc+1, or 0 with wrapped=1 when pc==PROG_LEN-1; -> IDLE.
REQ-019 Step pulses arriving in ISSUE or ADVANCE SHALL be dropped, not queued.
REQ-020 instr SHALL be registered; update latency from pc change to instr = 1 cycle, always settled before the next ISSUE.
REQ-021 Handshake: transfer occurs exactly on a cycle with instr_valid&instr_ready; instr_valid SHALL NOT drop before a transfer.
REQ-022 ROM contents SHALL be a constant array; words beyond PROG_LEN unused.

Reset
REQ-023 rst_n low SHALL immediately force: state=IDLE, pc=0, instr=0, instr_valid=0, wrapped=0, synchronizer=released, debounce counter=0, filtered level=0.
REQ-024 Reset mid-ISSUE SHALL abandon the offer with no transfer; after release, first step reissues ROM[0].
REQ-025 Button held across reset deassertion SHALL produce a step pulse only after DB_CYCLES stable cycles.

Configuration
REQ-026 Macro AUTORUN_EN: when defined, IDLE SHALL transition to ISSUE every cycle without a step pulse, streaming the program back-to-back and wrapping continuously; step_btn then only re-starts from pc=0 on a step pulse (pc<=0 in ADVANCE priority). Undefined: step-only behaviour of REQ-016.

Structure
REQ-027 Package instr_pkg SHALL hold INSTR_W, opcode constants (LOAD=4'b0010, ADD=4'b0011, SUB=4'b0100, MUL=4'b0101, TRANSP=4'b0110, OPP=4'b0111, DET=4'b1011) and the program ROM constant array.
REQ-028 Sub-module btn_debounce SHALL contain synchronizer, counter and edge detector, output step pulse.

Verification
REQ-029 Reset, DB_CYCLES=4, one clean press, instr_ready=1 -> instr_valid high one cycle with instr=ROM[0], pc then 1.
REQ-030 Press with 3-cycle glitches shorter than DB_CYCLES -> no step pulse, instr_valid stays 0.
REQ-031 Press with instr_ready=0 for 10 cycles -> instr/instr_valid stable all 10 cycles; transfer on ready high; second press during wait ignored.
REQ-032 PROG_LEN=21, 21 presses -> wrapped pulses once after 21st transfer, pc=0, next press gives ROM[0].
REQ-033 rst_n low during ISSUE at pc=5 -> outputs zero asynchronously; next press issues ROM[0].
REQ-034 AUTORUN_EN defined, instr_ready=1 -> one transfer every 2 cycles, pc sequence 0..20,0; press mid-run restarts at 0.
